// File: rtl/request_scheduler.sv
// request_scheduler: FCFS grant of one resource among N requesters; same-cycle arrivals ordered round-robin.
// Enqueue one cycle after req rises, grant one cycle after reaching the head; hold timeout compiled in with REQSCHED_TIMEOUT_EN.
module request_scheduler #(
    parameter int N = 4,
    parameter int MAX_HOLD = 16,
    localparam int IDW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic [CW-1:0]  queue_count,
    output logic           timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t         state;
    logic [IDW-1:0] fifo [N];
    logic [IDW-1:0] head;
    logic [IDW-1:0] tail;
    logic [IDW-1:0] rr_ptr;
    logic [N-1:0]   inq;
    logic [N-1:0]   pending;
    logic           push;
    logic           pop;
    logic [IDW-1:0] push_id;
    logic [IDW-1:0] head_id;

`ifdef REQSCHED_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_cnt;
`endif

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        return (int'(v) == N - 1) ? '0 : v + IDW'(1);
    endfunction

    // The granted requester is excluded so a held request is not queued a second time.
    assign pending = req & ~inq & ~gnt;
    assign head_id = fifo[head];
    assign pop     = (state == IDLE) && (queue_count != '0);

    always_comb begin
        logic [IDW-1:0] cand;
        push    = 1'b0;
        push_id = '0;
        cand    = '0;
        // Scan downward so the candidate closest to rr_ptr is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            cand = IDW'((int'(rr_ptr) + i) % N);
            if (pending[cand]) begin
                push    = 1'b1;
                push_id = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            gnt_vld     <= 1'b0;
            queue_count <= '0;
            timeout     <= 1'b0;
            rr_ptr      <= '0;
            head        <= '0;
            tail        <= '0;
            inq         <= '0;
`ifdef REQSCHED_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            if (push) begin
                fifo[tail]   <= push_id;
                tail         <= wrap_inc(tail);
                inq[push_id] <= 1'b1;
                rr_ptr       <= wrap_inc(push_id);
            end
            if (pop) begin
                head         <= wrap_inc(head);
                inq[head_id] <= 1'b0;
            end
            if (push && !pop) begin
                queue_count <= queue_count + CW'(1);
            end else if (!push && pop) begin
                queue_count <= queue_count - CW'(1);
            end

            case (state)
                IDLE: begin
                    // A withdrawn head is popped and dropped without a grant.
                    if (pop && req[head_id]) begin
                        state   <= GRANT;
                        gnt     <= N'(1) << head_id;
                        gnt_id  <= head_id;
                        gnt_vld <= 1'b1;
`ifdef REQSCHED_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        state   <= GAP;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                    end
`ifdef REQSCHED_TIMEOUT_EN
                    else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        state   <= GAP;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
